// File: rtl/uart_rx_param.sv
// uart_rx_param -- parametrised UART receiver.
//
// Receives asynchronous serial frames on rx. Each frame is one start bit,
// DATA_BITS data bits (LSB first), an optional parity bit and STOP_BITS stop
// bits. The frame is timed by br_tick, which pulses OVERSAMPLE times per bit.
// The completed word is offered on a valid/ready output together with
// parity, framing and overrun status.
//
// Parameters:
//   DATA_BITS  (5..9)          data bits per frame
//   OVERSAMPLE (even, 8..32)   br_tick pulses per bit period
//   PARITY     (0/1/2)         none / odd / even
//   STOP_BITS  (1..2)          stop bits per frame
//
// Ports:
//   clk          in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   rx           in   serial line, asynchronous to clk, idle high
//   br_tick      in   one-clk oversample strobe
//   rx_data      out  received word, bit 0 = first data bit on the line
//   rx_valid     out  word available, held until accepted
//   rx_ready     in   consumer ready
//   parity_err   out  parity mismatch for the current rx_data
//   frame_err    out  a stop bit sampled 0 for the current rx_data
//   overrun_err  out  the previous unaccepted word was overwritten
//   busy         out  receiver is inside a frame (FSM not IDLE)
//   state_dbg    out  raw FSM state, for debug and checker binding
//
// Build option:
//   UART_RX_MAJORITY_EN  when defined, every sample is the 2-of-3 majority
//                        of the synchronised line on the br_ticks at the
//                        nominal sample tick -2, -1 and 0. When undefined,
//                        a single sample is taken at the nominal tick.
//                        Frame latency is the same in both builds.
//
// Handshake: a word is transferred in every cycle where rx_valid && rx_ready
// are both high. rx_valid stays high until that happens and drops on the
// following cycle. rx_data and the error flags hold until the next frame
// completes. A completion landing in the same cycle as an acceptance
// replaces the word without flagging an overrun.

module uart_rx_param #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rx,
    input  logic                 br_tick,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 busy,
    output logic [2:0]           state_dbg
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    // Start bit is checked at its middle; every later bit is checked one
    // full bit period after the previous sample, i.e. also mid-bit.
    localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_END  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t               state;
    logic [TW-1:0]        tcnt;
    logic [BW-1:0]        bcnt;
    logic                 scnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 perr_q;
    logic                 fflag_q;

    // Two-flop synchroniser; resets to the idle (high) line level.
    logic rx_meta;
    logic rxs;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    // Value of the line as seen at a sample point.
    logic sample;

`ifdef UART_RX_MAJORITY_EN
    // hist[1] is rxs at the tick two before the current one, hist[0] at the
    // tick just before. Combined with the live rxs this gives the three
    // votes at the nominal sample tick.
    logic [1:0] hist;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist <= 2'b11;
        end else if (br_tick) begin
            hist <= {hist[0], rxs};
        end
    end

    assign sample = (hist[1] & hist[0]) | (hist[1] & rxs) | (hist[0] & rxs);
`else
    assign sample = rxs;
`endif

    // Parity error for the word now in shreg plus the sampled parity bit.
    logic par_xor;
    logic par_bad;
    assign par_xor = (^shreg) ^ sample;
    assign par_bad = (PARITY == 1) ? ~par_xor : par_xor;

    logic last_stop;
    assign last_stop = (STOP_BITS == 1) || scnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            tcnt        <= '0;
            bcnt        <= '0;
            scnt        <= 1'b0;
            shreg       <= '0;
            perr_q      <= 1'b0;
            fflag_q     <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            // Acceptance; a completion below in the same cycle wins.
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (!rxs) begin
                        state <= S_START;
                        tcnt  <= '0;
                    end
                end

                S_START: begin
                    if (br_tick) begin
                        if (tcnt == T_MID) begin
                            tcnt <= '0;
                            if (sample) begin
                                // Line back high mid start bit: a glitch.
                                state <= S_IDLE;
                            end else begin
                                state   <= S_DATA;
                                bcnt    <= '0;
                                perr_q  <= 1'b0;
                                fflag_q <= 1'b0;
                            end
                        end else begin
                            tcnt <= tcnt + TW'(1);
                        end
                    end
                end

                S_DATA: begin
                    if (br_tick) begin
                        if (tcnt == T_END) begin
                            tcnt  <= '0;
                            // Shift in from the top so the first bit ends in bit 0.
                            shreg <= {sample, shreg[DATA_BITS-1:1]};
                            if (bcnt == B_LAST) begin
                                state <= (PARITY != 0) ? S_PARITY : S_STOP;
                                scnt  <= 1'b0;
                            end else begin
                                bcnt <= bcnt + BW'(1);
                            end
                        end else begin
                            tcnt <= tcnt + TW'(1);
                        end
                    end
                end

                S_PARITY: begin
                    if (br_tick) begin
                        if (tcnt == T_END) begin
                            tcnt   <= '0;
                            perr_q <= par_bad;
                            state  <= S_STOP;
                        end else begin
                            tcnt <= tcnt + TW'(1);
                        end
                    end
                end

                S_STOP: begin
                    if (br_tick) begin
                        if (tcnt == T_END) begin
                            tcnt <= '0;
                            if (last_stop) begin
                                // Finish at the stop sample, not the end of the
                                // stop bit, so a following start edge half a bit
                                // later is still caught.
                                state       <= S_IDLE;
                                rx_data     <= shreg;
                                parity_err  <= perr_q;
                                frame_err   <= fflag_q | ~sample;
                                overrun_err <= rx_valid && !rx_ready;
                                rx_valid    <= 1'b1;
                            end else begin
                                scnt    <= 1'b1;
                                fflag_q <= fflag_q | ~sample;
                            end
                        end else begin
                            tcnt <= tcnt + TW'(1);
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_uart_rx_param.sv
`timescale 1ns/1ps

module tb_uart_rx_param;

  localparam int OVS      = 16;
  localparam int TICK_DIV = 4;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // br_tick: one clk high every TICK_DIV clks; tick_cnt numbers the ticks.
  logic br_tick;
  int   tick_cnt;
  int   div_cnt;

  initial begin
    br_tick  = 1'b0;
    tick_cnt = 0;
    div_cnt  = 0;
    forever begin
      @(negedge clk);
      if (div_cnt == TICK_DIV - 1) begin
        div_cnt  = 0;
        br_tick  = 1'b1;
        tick_cnt = tick_cnt + 1;
      end else begin
        div_cnt = div_cnt + 1;
        br_tick = 1'b0;
      end
    end
  end

  // ---------------- DUTs ----------------
  // dut0: 8N1. dut1: 8 data, even parity, 2 stop bits.
  logic       rx0, rx1, rdy0, rdy1;
  logic [7:0] d0_data, d1_data;
  logic       d0_valid, d0_pe, d0_fe, d0_oe, d0_busy;
  logic       d1_valid, d1_pe, d1_fe, d1_oe, d1_busy;
  logic [2:0] d0_state, d1_state;

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(OVS), .PARITY(0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .rx(rx0), .br_tick(br_tick),
    .rx_data(d0_data), .rx_valid(d0_valid), .rx_ready(rdy0),
    .parity_err(d0_pe), .frame_err(d0_fe), .overrun_err(d0_oe),
    .busy(d0_busy), .state_dbg(d0_state)
  );

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(OVS), .PARITY(2), .STOP_BITS(2)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .rx(rx1), .br_tick(br_tick),
    .rx_data(d1_data), .rx_valid(d1_valid), .rx_ready(rdy1),
    .parity_err(d1_pe), .frame_err(d1_fe), .overrun_err(d1_oe),
    .busy(d1_busy), .state_dbg(d1_state)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec = n_vec + 1;
    exp_q.push_back(exp);
    assert (obs === exp_q.pop_front())
    else begin
      n_err = n_err + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accepted-word monitors (transfer = valid && ready, seen just after the edge).
  int         cap0_cnt = 0, cap1_cnt = 0;
  logic [7:0] cap0_data, cap1_data;
  logic       cap0_pe, cap0_fe, cap0_oe, cap1_pe, cap1_fe, cap1_oe;
  int         cap0_tick, cap1_tick;

  always @(posedge clk) begin
    #1;
    if (d0_valid && rdy0) begin
      cap0_cnt  = cap0_cnt + 1;
      cap0_data = d0_data;
      cap0_pe   = d0_pe;
      cap0_fe   = d0_fe;
      cap0_oe   = d0_oe;
      cap0_tick = tick_cnt;
    end
  end

  always @(posedge clk) begin
    #1;
    if (d1_valid && rdy1) begin
      cap1_cnt  = cap1_cnt + 1;
      cap1_data = d1_data;
      cap1_pe   = d1_pe;
      cap1_fe   = d1_fe;
      cap1_oe   = d1_oe;
      cap1_tick = tick_cnt;
    end
  end

  // ---------------- reference model ----------------
  // lvq[k-1] is the line level during the interval ending at tick k, where
  // tick 1 is the first br_tick after the start edge.
  logic       lvq[$];
  logic [7:0] exp_data;
  logic       exp_pe, exp_fe;
  int         exp_lat;
  int         start_tick;

  function automatic logic samp(input int k);
`ifdef UART_RX_MAJORITY_EN
    logic a, b, c;
    a = lvq[k-3];
    b = lvq[k-2];
    c = lvq[k-1];
    return (a & b) | (a & c) | (b & c);
`else
    return lvq[k-1];
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_tick();
    do @(posedge clk); while (br_tick !== 1'b1);
    #1;
  endtask

  task automatic set_rx(input int sel, input logic v);
    if (sel == 0) rx0 = v;
    else rx1 = v;
  endtask

  // Builds the per-tick line levels for one frame, computes the expected
  // word from them, then drives the line up to the final stop sample and
  // returns it to idle for idle_ticks ticks.
  task automatic send_frame(input int sel, input logic [7:0] data, input logic pbit,
                            input logic [1:0] stop_v, input int glitch_k, input int idle_ticks);
    int   haspar, nstop;
    logic p;
    haspar = (sel == 1) ? 1 : 0;
    nstop  = (sel == 1) ? 2 : 1;
    lvq.delete();
    repeat (OVS) lvq.push_back(1'b0);
    for (int i = 0; i < 8; i++) repeat (OVS) lvq.push_back(data[i]);
    if (haspar == 1) repeat (OVS) lvq.push_back(pbit);
    for (int s = 0; s < nstop; s++) repeat (OVS) lvq.push_back(stop_v[s]);
    if (glitch_k > 0) lvq[glitch_k-1] = 1'b0;

    exp_lat = OVS / 2 + OVS * (8 + haspar + nstop);
    for (int i = 0; i < 8; i++) exp_data[i] = samp(OVS / 2 + OVS * (i + 1));
    exp_pe = 1'b0;
    if (haspar == 1) begin
      p      = samp(OVS / 2 + OVS * 9);
      exp_pe = ^{exp_data, p};
    end
    exp_fe = 1'b0;
    for (int s = 0; s < nstop; s++)
      if (!samp(OVS / 2 + OVS * (9 + haspar + s))) exp_fe = 1'b1;

    wait_tick();
    start_tick = tick_cnt;
    for (int k = 1; k <= exp_lat; k++) begin
      set_rx(sel, lvq[k-1]);
      wait_tick();
    end
    set_rx(sel, 1'b1);
    repeat (idle_ticks) wait_tick();
  endtask

  // Checks one accepted word against explicit expectations; the delivery
  // tick is checked against the frame length from the spec's formula.
  task automatic check_cap(input string tag, input int sel, input int prev,
                           input logic [7:0] ed, input logic epe, input logic efe);
    int cnt, tk;
    logic [7:0] d;
    logic pe, fe, oe;
    if (sel == 0) begin
      cnt = cap0_cnt; d = cap0_data; pe = cap0_pe; fe = cap0_fe; oe = cap0_oe; tk = cap0_tick;
    end else begin
      cnt = cap1_cnt; d = cap1_data; pe = cap1_pe; fe = cap1_fe; oe = cap1_oe; tk = cap1_tick;
    end
    chk({tag, ".count"},       32'(cnt),              32'(prev + 1));
    chk({tag, ".rx_data"},     32'(d),                32'(ed));
    chk({tag, ".parity_err"},  32'(pe),               32'(epe));
    chk({tag, ".frame_err"},   32'(fe),               32'(efe));
    chk({tag, ".overrun_err"}, 32'(oe),               32'(1'b0));
    chk({tag, ".latency"},     32'(tk - start_tick),  32'(exp_lat));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int pc;
    logic [7:0] rd;
    logic [1:0] sv;
    logic pb;
    int gk;

    reset_n = 1'b0;
    rx0 = 1'b1; rx1 = 1'b1;
    rdy0 = 1'b1; rdy1 = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("reset.rx_data",     32'(d0_data),  32'h0);
    chk("reset.rx_valid",    32'(d0_valid), 32'h0);
    chk("reset.parity_err",  32'(d0_pe),    32'h0);
    chk("reset.frame_err",   32'(d0_fe),    32'h0);
    chk("reset.overrun_err", 32'(d0_oe),    32'h0);
    chk("reset.busy",        32'(d0_busy),  32'h0);
    chk("reset.d1_valid",    32'(d1_valid), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) wait_tick();

    // 8N1 0xA5, ready high: single-cycle valid, 152-tick latency.
    pc = cap0_cnt;
    send_frame(0, 8'hA5, 1'b0, 2'b11, 0, 32);
    check_cap("a5", 0, pc, 8'hA5, 1'b0, 1'b0);
    chk("a5.latency_152", 32'(exp_lat), 32'd152);
    chk("a5.valid_after", 32'(d0_valid), 32'h0);

    // Even parity, wrong parity bit then correct one.
    pc = cap1_cnt;
    send_frame(1, 8'h03, 1'b1, 2'b11, 0, 32);
    check_cap("par_bad", 1, pc, 8'h03, 1'b1, 1'b0);
    pc = cap1_cnt;
    send_frame(1, 8'h03, 1'b0, 2'b11, 0, 32);
    check_cap("par_ok", 1, pc, 8'h03, 1'b0, 1'b0);

    // Stop bit forced low, then a break.
    pc = cap0_cnt;
    send_frame(0, 8'h5A, 1'b0, 2'b00, 0, 32);
    check_cap("stop0", 0, pc, 8'h5A, 1'b0, 1'b1);
    pc = cap0_cnt;
    send_frame(0, 8'h00, 1'b0, 2'b00, 0, 32);
    check_cap("break", 0, pc, 8'h00, 1'b0, 1'b1);

    // False start: 4 ticks low then high.
    wait_tick();
    pc = cap0_cnt;
    rx0 = 1'b0;
    repeat (2) wait_tick();
    chk("glitch.busy_high", 32'(d0_busy), 32'h1);
    repeat (2) wait_tick();
    rx0 = 1'b1;
    repeat (2 * OVS) wait_tick();
    chk("glitch.busy_low", 32'(d0_busy),  32'h0);
    chk("glitch.no_word",  32'(cap0_cnt), 32'(pc));
    chk("glitch.valid",    32'(d0_valid), 32'h0);
    pc = cap0_cnt;
    send_frame(0, 8'h3C, 1'b0, 2'b11, 0, 32);
    check_cap("after_glitch", 0, pc, 8'h3C, 1'b0, 1'b0);

    // 1-tick low glitch at the bit-3 sample point of 0xFF.
    pc = cap0_cnt;
    send_frame(0, 8'hFF, 1'b0, 2'b11, OVS / 2 + OVS * 4, 32);
`ifdef UART_RX_MAJORITY_EN
    check_cap("bit3_glitch", 0, pc, 8'hFF, 1'b0, 1'b0);
`else
    check_cap("bit3_glitch", 0, pc, 8'hF7, 1'b0, 1'b0);
`endif

    // Overrun: two words with nobody accepting.
    rdy0 = 1'b0;
    send_frame(0, 8'h11, 1'b0, 2'b11, 0, 8);
    chk("ovr1.valid",   32'(d0_valid), 32'h1);
    chk("ovr1.rx_data", 32'(d0_data),  32'h11);
    chk("ovr1.overrun", 32'(d0_oe),    32'h0);
    send_frame(0, 8'h22, 1'b0, 2'b11, 0, 8);
    chk("ovr2.valid",   32'(d0_valid), 32'h1);
    chk("ovr2.rx_data", 32'(d0_data),  32'h22);
    chk("ovr2.overrun", 32'(d0_oe),    32'h1);
    @(negedge clk);
    rdy0 = 1'b1;
    @(negedge clk);
    rdy0 = 1'b0;
    chk("accept.valid_drop", 32'(d0_valid), 32'h0);
    chk("accept.data_held",  32'(d0_data),  32'h22);
    chk("accept.oe_held",    32'(d0_oe),    32'h1);

    // Reset in the middle of a frame.
    wait_tick();
    rx0 = 1'b0;
    repeat (40) wait_tick();
    chk("midrst.busy_before", 32'(d0_busy), 32'h1);
    reset_n = 1'b0;
    #1;
    chk("midrst.rx_data",     32'(d0_data),  32'h0);
    chk("midrst.rx_valid",    32'(d0_valid), 32'h0);
    chk("midrst.parity_err",  32'(d0_pe),    32'h0);
    chk("midrst.frame_err",   32'(d0_fe),    32'h0);
    chk("midrst.overrun_err", 32'(d0_oe),    32'h0);
    chk("midrst.busy",        32'(d0_busy),  32'h0);
    rx0 = 1'b1;
    rdy0 = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) wait_tick();

    // Randomised frames on both receivers, model-checked.
    for (int n = 0; n < 6; n++) begin
      rd = 8'($urandom_range(0, 255));
      sv = {1'b1, ($urandom_range(0, 3) != 0)};
      gk = ($urandom_range(0, 1) == 1) ? (OVS / 2 + OVS * (1 + $urandom_range(0, 7))) : 0;
      pc = cap0_cnt;
      send_frame(0, rd, 1'b0, sv, gk, 32);
      check_cap($sformatf("rnd0_%0d", n), 0, pc, exp_data, exp_pe, exp_fe);
    end
    for (int n = 0; n < 6; n++) begin
      rd = 8'($urandom_range(0, 255));
      pb = 1'($urandom_range(0, 1));
      sv = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
      pc = cap1_cnt;
      send_frame(1, rd, pb, sv, 0, 32);
      check_cap($sformatf("rnd1_%0d", n), 1, pc, exp_data, exp_pe, exp_fe);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
